mag_comp_seq: RTL and testbench

- Parametrised, sequential successor to the 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands one DIGIT-bit slice per clock, MSB slice first, in unsigned or two's-complement mode.
- Uses a start/busy/done handshake and can terminate early on the first differing slice.
- Used where wide operands would make a single-cycle comparator timing-critical.

---
 rtl/mag_comp_seq.sv | 110 +++++++++++
 tb/tb_mag_comp_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_comp_seq.sv
// mag_comp_seq: sequential WIDTH-bit magnitude comparator.
// Walks DIGIT-bit slices MSB first, unsigned or two's-complement.
module mag_comp_seq #(
   parameter int WIDTH      = 16,
   parameter int DIGIT      = 4,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             Equal,
   output logic             Greater,
   output logic             Small
);

   localparam int N  = WIDTH / DIGIT;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]    K_LAST = KW'(N - 1);
   localparam logic [WIDTH-1:0] MSB    = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             seen;
   logic             seen_gt;

   logic [DIGIT-1:0] a_top;
   logic [DIGIT-1:0] b_top;
   logic             diff;
   logic             gt;
   logic             last;
   logic             accept;

   // Operands shift left each RUN cycle, so the live slice is always on top.
   assign a_top  = a_q[WIDTH-1 -: DIGIT];
   assign b_top  = b_q[WIDTH-1 -: DIGIT];
   assign diff   = (a_top != b_top);
   assign gt     = (a_top > b_top);
   assign last   = (k == K_LAST);
   assign accept = start && (state != RUN);

   // Control FSM with registered handshake and result flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         k       <= '0;
         a_q     <= '0;
         b_q     <= '0;
         seen    <= 1'b0;
         seen_gt <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         Equal   <= 1'b0;
         Greater <= 1'b0;
         Small   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            // Flipping the MSB maps signed order onto unsigned order.
            a_q     <= signed_mode ? (A ^ MSB) : A;
            b_q     <= signed_mode ? (B ^ MSB) : B;
            k       <= '0;
            seen    <= 1'b0;
            seen_gt <= 1'b0;
            Equal   <= 1'b0;
            Greater <= 1'b0;
            Small   <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
         end else begin
            unique case (state)
               RUN: begin
                  if (!seen && diff) begin
                     seen    <= 1'b1;
                     seen_gt <= gt;
                  end
                  if ((EARLY_EXIT && diff) || last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                     if (seen) begin
                        Greater <= seen_gt;
                        Small   <= !seen_gt;
                     end else if (diff) begin
                        Greater <= gt;
                        Small   <= !gt;
                     end else begin
                        Equal <= 1'b1;
                     end
                  end else begin
                     k   <= k + 1'b1;
                     a_q <= a_q << DIGIT;
                     b_q <= b_q << DIGIT;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mag_comp_seq.sv
// tb_mag_comp_seq: directed checks of mag_comp_seq.
// Covers 16/4 in both exit modes plus an exhaustive 4/1 sweep.
module tb_mag_comp_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st16 = 1'b0;
   logic        sm16 = 1'b0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        st4 = 1'b0;
   logic        sm4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;

   logic bz16e, d16e, eq16e, gt16e, sl16e;
   logic bz16c, d16c, eq16c, gt16c, sl16c;
   logic bz4e, d4e, eq4e, gt4e, sl4e;
   logic bz4c, d4c, eq4c, gt4c, sl4c;
   logic [2:0] f16e, f16c, f4e, f4c;

   assign f16e = {eq16e, gt16e, sl16e};
   assign f16c = {eq16c, gt16c, sl16c};
   assign f4e  = {eq4e, gt4e, sl4e};
   assign f4c  = {eq4c, gt4c, sl4c};

   int checks = 0;
   int errors = 0;
   int lat_e;
   int lat_c;
   int inv_bad = 0;

   always #5 clk = ~clk;

   mag_comp_seq #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) u16e (
      .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16),
      .A(a16), .B(b16), .busy(bz16e), .done(d16e),
      .Equal(eq16e), .Greater(gt16e), .Small(sl16e));

   mag_comp_seq #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b0)) u16c (
      .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16),
      .A(a16), .B(b16), .busy(bz16c), .done(d16c),
      .Equal(eq16c), .Greater(gt16c), .Small(sl16c));

   mag_comp_seq #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(1'b1)) u4e (
      .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4),
      .A(a4), .B(b4), .busy(bz4e), .done(d4e),
      .Equal(eq4e), .Greater(gt4e), .Small(sl4e));

   mag_comp_seq #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(1'b0)) u4c (
      .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4),
      .A(a4), .B(b4), .busy(bz4c), .done(d4c),
      .Equal(eq4c), .Greater(gt4c), .Small(sl4c));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one 16-bit request to both 16-bit instances; latency in edges.
   task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                          input logic sm);
      @(negedge clk);
      a16 = a; b16 = b; sm16 = sm; st16 = 1'b1;
      @(posedge clk);
      #1 st16 = 1'b0;
      lat_e = -1;
      lat_c = -1;
      for (int n = 0; n < 30 && (lat_e < 0 || lat_c < 0); n++) begin
         @(negedge clk);
         if (bz16e && f16e != 3'b000) inv_bad++;
         if (bz16c && f16c != 3'b000) inv_bad++;
         if (d16e && lat_e < 0) begin
            lat_e = n;
            if (!$onehot(f16e)) inv_bad++;
         end
         if (d16c && lat_c < 0) begin
            lat_c = n;
            if (!$onehot(f16c)) inv_bad++;
         end
      end
   endtask

   task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                         input logic sm);
      @(negedge clk);
      a4 = a; b4 = b; sm4 = sm; st4 = 1'b1;
      @(posedge clk);
      #1 st4 = 1'b0;
      lat_e = -1;
      lat_c = -1;
      for (int n = 0; n < 30 && (lat_e < 0 || lat_c < 0); n++) begin
         @(negedge clk);
         if (bz4e && f4e != 3'b000) inv_bad++;
         if (bz4c && f4c != 3'b000) inv_bad++;
         if (d4e && lat_e < 0) begin
            lat_e = n;
            if (!$onehot(f4e)) inv_bad++;
         end
         if (d4c && lat_c < 0) begin
            lat_c = n;
            if (!$onehot(f4c)) inv_bad++;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int bad_re, bad_rc, bad_le, bad_lc;

      #12;
      chk("reset_state16", {bz16e, d16e, f16e}, 5'b00000);
      chk("reset_state4", {bz4e, d4e, f4e}, 5'b00000);
      @(negedge clk);
      rst = 1'b0;

      // Equal operands: full walk, result held afterwards.
      issue16(16'h1234, 16'h1234, 1'b0);
      chk("eq_lat_e", lat_e, 4);
      chk("eq_flags_e", f16e, 3'b100);
      chk("eq_lat_c", lat_c, 4);
      repeat (3) @(negedge clk);
      chk("eq_hold", {bz16e, d16e, f16e}, 5'b00100);

      // MSB slice decides; signed mode flips the order.
      issue16(16'h8000, 16'h7FFF, 1'b0);
      chk("u_msb_lat_e", lat_e, 1);
      chk("u_msb_flags_e", f16e, 3'b010);
      chk("u_msb_lat_c", lat_c, 4);
      chk("u_msb_flags_c", f16c, 3'b010);
      issue16(16'h8000, 16'h7FFF, 1'b1);
      chk("s_msb_lat_e", lat_e, 1);
      chk("s_msb_flags_e", f16e, 3'b001);
      chk("s_msb_flags_c", f16c, 3'b001);

      // LSB slice decides.
      issue16(16'h1235, 16'h1234, 1'b0);
      chk("lsb_lat_e", lat_e, 4);
      chk("lsb_flags_e", f16e, 3'b010);
      chk("lsb_flags_c", f16c, 3'b010);
      issue16(16'h9234, 16'h1234, 1'b0);
      chk("const_lat_c", lat_c, 4);
      chk("const_flags_c", f16c, 3'b010);
      chk("const_lat_e", lat_e, 1);
      issue16(16'hFFFE, 16'h0001, 1'b1);
      chk("s_neg_flags_e", f16e, 3'b001);
      chk("s_neg_flags_c", f16c, 3'b001);

      // Start during RUN is ignored; start in DONE is accepted.
      @(negedge clk);
      a16 = 16'd5; b16 = 16'd9; sm16 = 1'b0; st16 = 1'b1;
      @(posedge clk);
      #1 st16 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a16 = 16'd9; b16 = 16'd5; st16 = 1'b1;
      @(negedge clk);
      st16 = 1'b0;
      cnt = 0;
      while (!d16e && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("hs_ignore_lat", cnt, 2);
      chk("hs_ignore_flags", f16e, 3'b001);
      st16 = 1'b1;
      @(negedge clk);
      st16 = 1'b0;
      chk("hs_b2b_accept", {bz16e, d16e, f16e}, 5'b10000);
      cnt = 0;
      while (!d16e && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("hs_b2b_lat", cnt, 4);
      chk("hs_b2b_flags", f16e, 3'b010);
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      a16 = 16'd1; b16 = 16'd1; st16 = 1'b1;
      @(posedge clk);
      #1 st16 = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_async_e", {bz16e, d16e, f16e}, 5'b00000);
      chk("rst_async_c", {bz16c, d16c, f16c}, 5'b00000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (d16e || d16c || bz16e || bz16c) cnt++;
      end
      chk("rst_no_done", cnt, 0);
      issue16(16'hABCD, 16'hABCE, 1'b0);
      chk("rst_after_lat", lat_e, 4);
      chk("rst_after_flags", f16e, 3'b001);

      // Exhaustive 4-bit sweep against an integer reference.
      bad_re = 0; bad_rc = 0; bad_le = 0; bad_lc = 0;
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               logic [3:0] av, bv, dv;
               logic [2:0] ex;
               int x, y, el;
               av = 4'(a);
               bv = 4'(b);
               x = (s == 1) ? int'($signed(av)) : a;
               y = (s == 1) ? int'($signed(bv)) : b;
               ex = (x == y) ? 3'b100 : (x > y) ? 3'b010 : 3'b001;
               dv = av ^ bv;
               el = 4;
               for (int i = 3; i >= 0; i--) begin
                  if (dv[i]) begin
                     el = 4 - i;
                     break;
                  end
               end
               issue4(av, bv, s[0]);
               if (f4e !== ex) bad_re++;
               if (f4c !== ex) bad_rc++;
               if (lat_e != el) bad_le++;
               if (lat_c != 4) bad_lc++;
            end
         end
      end
      chk("sweep_res_e", bad_re, 0);
      chk("sweep_res_c", bad_rc, 0);
      chk("sweep_lat_e", bad_le, 0);
      chk("sweep_lat_c", bad_lc, 0);
      chk("invariants", inv_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
